register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised multi-port successor to the single-write, two-read CPU register file.
- Writes on the rising edge (no negedge clocking) with combinational write-to-read bypass, so a value written this cycle is readable in the same cycle.
- Adds NWR write ports with fixed priority, a per-register pending scoreboard for hazard detection, and an optional hardwired zero register.
- Sits between decode (reads, issue) and writeback (writes) in the pipelined datapath.

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of registers; power of two, at least 2.
- AW, $clog2(NREG), register index width; derived, not overridden.
- NRD, 2, number of read ports.
- NWR, 2, number of write ports.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never pending.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- wen  in  NWR  per-port write enable.
- wsel  in  NWR*AW  write index; port k occupies bits [k*AW +: AW].
- wdat  in  NWR*DW  write data; port k occupies bits [k*DW +: DW].
- rsel  in  NRD*AW  read index per port.
- rdat  out  NRD*DW  read data per port.
- rpend  out  NRD  per-port flag: the addressed register is still pending after this cycle's writes.
- iss_en  in  1  issue: mark register iss_sel pending.
- iss_sel  in  AW  destination register being issued.
- pend_vec  out  NREG  full scoreboard state; registered, no bypass.

Behaviour:
- Reset (nRST low, async): all registers = 0 and all pending bits = 0, immediately. rdat = 0, rpend = 0, pend_vec = 0 while held in reset.
- Write: on the rising edge, for each port k with wen[k]=1, reg[wsel_k] <= wdat_k. Latency is 1 edge for storage.
- Write conflict: if several enabled ports target the same register, the highest-index port wins, both for storage and for bypass.
- Read: combinational, zero latency, evaluated per port p.
  - Any enabled write port has wsel == rsel_p: rdat_p = data of the winning (highest-index) such port. This is the bypass.
  - Otherwise rdat_p = reg[rsel_p].
- Zero register (ZERO_REG=1):
  - Reads of index 0 return 0, with no bypass.
  - Writes to index 0 are dropped and do not count as winners.
  - Issue to 0 is ignored; pend_vec[0] is always 0.
- Scoreboard, next-state per register r:
  - iss_en=1 and iss_sel==r: pend[r] <= 1. Issue beats a same-cycle clear because the issued instruction is newer.
  - Else, any enabled write targets r: pend[r] <= 0.
  - Else: pend[r] holds.
- rpend_p is combinational:
  - 0 if an enabled write targets rsel_p this cycle, since the bypass covers it.
  - Otherwise pend[rsel_p].
  - Same-cycle issue does not affect rpend; it is visible from the next cycle only.
- Writing a non-pending register is legal: data updates, scoreboard is unchanged (stays 0).
- Reset asserted mid-operation overrides any in-flight write or issue on that edge.
- No X propagation: out-of-range indices cannot occur because NREG = 2^AW.

Test Plan:
- Reset check: after nRST pulse, all rsel 0..NREG-1 -> rdat=0 and pend_vec=0. Write 0xDEADBEEF to r5, then assert nRST mid-cycle -> r5 reads 0 immediately.
- Bypass: wen[0]=1, wsel0=7, wdat0=0x12345678, rsel0=7 in the same cycle -> rdat0=0x12345678 before the edge. The next cycle without a write still reads 0x12345678.
- Write conflict: port0 writes r3=0x1, port1 writes r3=0x2 in the same cycle -> bypass and stored value are both 0x2.
- Zero register: write r0=0xFFFFFFFF on port1 with rsel0=0 -> rdat0=0 in that cycle and after. Issue to 0 -> pend_vec[0]=0.
- Scoreboard: issue r9 -> next cycle pend_vec[9]=1 and rpend for rsel=9 is 1. Then write r9=0xA5 -> rpend drops to 0 in the same cycle with rdat=0xA5, and pend_vec[9]=0 after the edge.
- Issue/write collision: iss_en on r4 with a same-cycle write to r4 -> after the edge pend_vec[4]=1 and r4 holds the written data.

Source files
------------

// File: rtl/register_file_mp_if.sv
// Decode/writeback-side bundle for register_file_mp: write ports, read ports,
// issue request and scoreboard view.
interface register_file_mp_if #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NWR-1:0]    wen;
    logic [NWR*AW-1:0] wsel;
    logic [NWR*DW-1:0] wdat;
    logic [NRD*AW-1:0] rsel;
    logic [NRD*DW-1:0] rdat;
    logic [NRD-1:0]    rpend;
    logic              iss_en;
    logic [AW-1:0]     iss_sel;
    logic [NREG-1:0]   pend_vec;

    modport master (
        output wen, wsel, wdat, rsel, iss_en, iss_sel,
        input  rdat, rpend, pend_vec
    );

    modport slave (
        input  wen, wsel, wdat, rsel, iss_en, iss_sel,
        output rdat, rpend, pend_vec
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file: NWR prioritised write ports with same-cycle bypass,
// NRD combinational read ports, per-register pending scoreboard, optional zero reg.
module register_file_mp #(
    parameter int DW       = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    register_file_mp_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0][DW-1:0] regs_q, regs_d;
    logic [NREG-1:0]         pend_q, pend_d;
    logic [NWR-1:0]          wvld;
    logic [NRD-1:0][DW-1:0]  rdat_w;
    logic [NRD-1:0]          rpend_w;

    function automatic logic is_zero(input logic [AW-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    // Writes to a hardwired zero register never count, neither for storage nor bypass.
    always_comb begin
        wvld = '0;
        for (int k = 0; k < NWR; k++)
            wvld[k] = bus.wen[k] && !is_zero(bus.wsel[k*AW +: AW]);
    end

    // Ascending port order: the highest-index port writing a register lands last.
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int k = 0; k < NWR; k++) begin
            if (wvld[k]) begin
                regs_d[bus.wsel[k*AW +: AW]] = bus.wdat[k*DW +: DW];
                pend_d[bus.wsel[k*AW +: AW]] = 1'b0;
            end
        end
        if (bus.iss_en && !is_zero(bus.iss_sel))
            pend_d[bus.iss_sel] = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regs_q <= '0;
            pend_q <= '0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
        end
    end

    always_comb begin
        rdat_w  = '0;
        rpend_w = '0;
        for (int p = 0; p < NRD; p++) begin
            logic          hit;
            logic [DW-1:0] byp;
            logic [AW-1:0] sel;
            sel = bus.rsel[p*AW +: AW];
            hit = 1'b0;
            byp = '0;
            for (int k = 0; k < NWR; k++) begin
                if (wvld[k] && (bus.wsel[k*AW +: AW] == sel)) begin
                    hit = 1'b1;
                    byp = bus.wdat[k*DW +: DW];
                end
            end
            // Outputs are forced quiet in reset so an in-flight bypass cannot leak out.
            if (!nRST || is_zero(sel))
                rdat_w[p] = '0;
            else if (hit)
                rdat_w[p] = byp;
            else
                rdat_w[p] = regs_q[sel];
            rpend_w[p] = nRST && !hit && pend_q[sel];
        end
    end

    assign bus.rdat     = rdat_w;
    assign bus.rpend    = rpend_w;
    assign bus.pend_vec = pend_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Randomised and directed checks of register_file_mp against an array-based model.
module tb_register_file_mp;
    localparam int DW   = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = $clog2(NREG);

    logic CLK;
    logic nRST;
    int   n_chk;
    int   n_fail;

    logic [DW-1:0] m_reg  [NREG];
    logic          m_pend [NREG];

    register_file_mp_if #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

    register_file_mp #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wsel_of(int k);
        return int'(bus.wsel[k*AW +: AW]);
    endfunction

    function automatic int rsel_of(int p);
        return int'(bus.rsel[p*AW +: AW]);
    endfunction

    // Highest-index enabled write port targeting idx, or -1; index 0 never matches.
    function automatic int winner(int idx);
        for (int k = NWR - 1; k >= 0; k--)
            if (bus.wen[k] && idx != 0 && wsel_of(k) == idx) return k;
        return -1;
    endfunction

    function automatic logic [DW-1:0] exp_rdat(int p);
        int s, w;
        s = rsel_of(p);
        w = winner(s);
        if (!nRST || s == 0) return '0;
        if (w >= 0) return bus.wdat[w*DW +: DW];
        return m_reg[s];
    endfunction

    function automatic logic exp_rpend(int p);
        int s;
        s = rsel_of(p);
        if (!nRST || winner(s) >= 0) return 1'b0;
        return m_pend[s];
    endfunction

    function automatic logic [NREG-1:0] exp_pvec();
        logic [NREG-1:0] v;
        for (int r = 0; r < NREG; r++) v[r] = m_pend[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_reg[r]  = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int r = 1; r < NREG; r++) begin
            int w;
            w = winner(r);
            if (bus.iss_en && int'(bus.iss_sel) == r) m_pend[r] = 1'b1;
            else if (w >= 0) m_pend[r] = 1'b0;
            if (w >= 0) m_reg[r] = bus.wdat[w*DW +: DW];
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int p = 0; p < NRD; p++) begin
            chk($sformatf("%s rdat%0d", tag, p), 64'(bus.rdat[p*DW +: DW]), 64'(exp_rdat(p)));
            chk($sformatf("%s rpend%0d", tag, p), 64'(bus.rpend[p]), 64'(exp_rpend(p)));
        end
        chk($sformatf("%s pend_vec", tag), 64'(bus.pend_vec), 64'(exp_pvec()));
    endtask

    // Inputs change only after the falling edge; outputs are checked just before the rising edge.
    task automatic tick(input string tag);
        #3;
        check_outputs(tag);
        @(posedge CLK);
        if (nRST) model_edge();
        @(negedge CLK);
    endtask

    task automatic idle();
        bus.wen    = '0;
        bus.wsel   = '0;
        bus.wdat   = '0;
        bus.iss_en = 1'b0;
        bus.iss_sel = '0;
    endtask

    task automatic set_wr(input int k, input int sel, input logic [DW-1:0] d);
        bus.wen[k]            = 1'b1;
        bus.wsel[k*AW +: AW]  = AW'(sel);
        bus.wdat[k*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int p, input int sel);
        bus.rsel[p*AW +: AW] = AW'(sel);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        nRST   = 1'b0;
        idle();
        bus.rsel = '0;
        model_reset();

        // Reset: every register reads 0, nothing pending.
        #2;
        for (int i = 0; i < NREG; i++) begin
            set_rd(0, i);
            set_rd(1, NREG - 1 - i);
            #1;
            check_outputs("reset");
        end
        @(negedge CLK);
        nRST = 1'b1;

        // Reset mid-operation wipes a stored value and overrides an in-flight write.
        set_wr(0, 5, 32'hDEADBEEF);
        set_rd(0, 5);
        tick("wr r5");
        idle();
        tick("rd r5");
        set_wr(0, 5, 32'h00000077);
        bus.iss_en  = 1'b1;
        bus.iss_sel = AW'(5);
        #2;
        nRST = 1'b0;
        model_reset();
        #1;
        chk("midrst rdat0", 64'(bus.rdat[DW-1:0]), 64'h0);
        @(negedge CLK);
        idle();
        nRST = 1'b1;
        tick("post rst");

        // Bypass, then stored value.
        set_wr(0, 7, 32'h12345678);
        set_rd(0, 7);
        tick("byp r7");
        idle();
        tick("hold r7");

        // Write conflict: port 1 wins both bypass and storage.
        set_wr(0, 3, 32'h1);
        set_wr(1, 3, 32'h2);
        set_rd(0, 3);
        set_rd(1, 3);
        tick("conflict r3");
        idle();
        tick("stored r3");

        // Zero register ignores writes and issue.
        set_wr(1, 0, 32'hFFFFFFFF);
        set_rd(0, 0);
        bus.iss_en  = 1'b1;
        bus.iss_sel = '0;
        tick("zero wr");
        idle();
        tick("zero after");

        // Scoreboard: issue r9, pending visible next cycle, cleared by writeback.
        bus.iss_en  = 1'b1;
        bus.iss_sel = AW'(9);
        set_rd(0, 9);
        tick("iss r9");
        idle();
        chk("pend_vec[9]", 64'(bus.pend_vec[9]), 64'h1);
        tick("pend r9");
        set_wr(0, 9, 32'hA5);
        tick("wb r9");
        idle();
        chk("pend_vec[9] clr", 64'(bus.pend_vec[9]), 64'h0);
        tick("after r9");

        // Issue beats a same-cycle write on the same register.
        bus.iss_en  = 1'b1;
        bus.iss_sel = AW'(4);
        set_wr(1, 4, 32'hCAFE0004);
        set_rd(1, 4);
        tick("iss+wr r4");
        idle();
        chk("pend_vec[4]", 64'(bus.pend_vec[4]), 64'h1);
        tick("r4 data");

        // Random traffic on a narrow index range to provoke conflicts and hazards.
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int k = 0; k < NWR; k++)
                if ($urandom_range(0, 1) == 1)
                    set_wr(k, int'($urandom_range(0, 7)), DW'($urandom));
            for (int p = 0; p < NRD; p++)
                set_rd(p, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG - 1))
                                                      : int'($urandom_range(0, 7)));
            bus.iss_en  = ($urandom_range(0, 2) == 0);
            bus.iss_sel = AW'($urandom_range(0, 7));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
